// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the M0 SoC interconnect.
//   htrans_t      : transfer type encoding
//   HRESP_*       : response encodings
//   dflt_state_t  : built-in default slave states
//   MAP_*         : default SoC memory map (region chosen by HADDR[31:28])
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } dflt_state_t;

  localparam logic [31:0] MAP_RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] MAP_SW_BASE     = 32'h4000_0000;
  localparam logic [31:0] MAP_DOUT_BASE   = 32'h5000_0000;
  localparam logic [31:0] MAP_REGION_MASK = 32'hF000_0000;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY do not.
  function automatic logic is_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped address space, with error logging.
// Active transfers get a two-cycle ERROR response; IDLE/BUSY get zero-wait OKAY.
//   state | meaning
//   IDLE  | no error in progress, HREADYOUT=1, HRESP=OKAY
//   ERR1  | first error cycle, HREADYOUT=0, HRESP=ERROR
//   ERR2  | second error cycle, HREADYOUT=1, HRESP=ERROR
// Ports:
//   HCLK, HRESETn  clock, async active-low reset
//   hready_i       bus HREADY (address phase accepted when high)
//   unmapped_i     address-phase decode found no slave
//   htrans_i       master HTRANS
//   haddr_i        master HADDR
//   hreadyout_o    default slave ready
//   hresp_o        default slave response
//   err_count_o    saturating count of completed ERROR responses
//   err_addr_o     address of the most recent unmapped active transfer
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             hready_i,
  input  logic             unmapped_i,
  input  logic [1:0]       htrans_i,
  input  logic [31:0]      haddr_i,
  output logic             hreadyout_o,
  output logic             hresp_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [31:0]      err_addr_o
);

  dflt_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             start;

  assign start = hready_i && unmapped_i && is_active(htrans_i);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    case (state_q)
      DS_IDLE: begin
        if (start) begin
          state_d = DS_ERR1;
          addr_d  = haddr_i;
        end
      end
      DS_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
        state_d     = DS_ERR2;
      end
      DS_ERR2: begin
        hresp_o = HRESP_ERROR;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (start) begin
          state_d = DS_ERR1;
          addr_d  = haddr_i;
        end else begin
          state_d = DS_IDLE;
        end
      end
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= DS_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign err_count_o = cnt_q;
  assign err_addr_o  = addr_q;

endmodule

// File: rtl/ahb_interconnect_n.sv
// AHB-Lite single-master interconnect for NSLAVES slaves plus a built-in
// default slave for unmapped space.
// Ports:
//   HCLK, HRESETn        clock, async active-low reset
//   HADDR, HTRANS        master address phase
//   HREADY, HRDATA, HRESP muxed data-phase response to master (HREADY also to slaves)
//   HSEL_SIGNALS         one-hot address-phase slave selects (pure decode)
//   HRDATA_SIGNALS       slave read data, slave i at [32i+:32]
//   HREADYOUT_SIGNALS    slave ready outputs
//   HRESP_SIGNALS        slave responses
//   err_count, err_addr  error log from the default slave
module ahb_interconnect_n
  import ahb_pkg::*;
#(
  parameter int                    NSLAVES   = 3,
  parameter logic [NSLAVES*32-1:0] BASE_ADDR = {MAP_DOUT_BASE, MAP_SW_BASE, MAP_RAM_BASE},
  parameter logic [NSLAVES*32-1:0] ADDR_MASK = {3{MAP_REGION_MASK}},
  parameter int                    CNT_W     = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  output logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic [NSLAVES-1:0]    HSEL_SIGNALS,
  input  logic [NSLAVES*32-1:0] HRDATA_SIGNALS,
  input  logic [NSLAVES-1:0]    HREADYOUT_SIGNALS,
  input  logic [NSLAVES-1:0]    HRESP_SIGNALS,
  output logic [CNT_W-1:0]      err_count,
  output logic [31:0]           err_addr
);

  logic [NSLAVES-1:0] hsel;
  logic               unmapped;
  logic [NSLAVES:0]   sel_q, sel_d;
  logic               dflt_ready;
  logic               dflt_resp;

  // Lowest index wins on overlapping regions, keeping hsel one-hot or zero.
  always_comb begin
    logic found;
    hsel  = '0;
    found = 1'b0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (!found && ((HADDR & ADDR_MASK[32*i +: 32]) == BASE_ADDR[32*i +: 32])) begin
        hsel[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign unmapped     = ~|hsel;
  assign HSEL_SIGNALS = hsel;

  // Top bit of sel_q marks the default slave as data-phase owner.
  assign sel_d = HREADY ? {unmapped, hsel} : sel_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) sel_q <= '0;
    else          sel_q <= sel_d;
  end

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    for (int i = 0; i < NSLAVES; i++) begin
      if (sel_q[i]) begin
        HRDATA = HRDATA_SIGNALS[32*i +: 32];
        HREADY = HREADYOUT_SIGNALS[i];
        HRESP  = HRESP_SIGNALS[i];
      end
    end
    if (sel_q[NSLAVES]) begin
      HRDATA = '0;
      HREADY = dflt_ready;
      HRESP  = dflt_resp;
    end
  end

  ahb_default_slave #(.CNT_W(CNT_W)) u_dflt (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .hready_i    (HREADY),
    .unmapped_i  (unmapped),
    .htrans_i    (HTRANS),
    .haddr_i     (HADDR),
    .hreadyout_o (dflt_ready),
    .hresp_o     (dflt_resp),
    .err_count_o (err_count),
    .err_addr_o  (err_addr)
  );

endmodule
